multicycle_mem_responder: RTL and testbench

MULTICYCLE_MEM_RESPONDER -- requirements
Module: multicycle_mem_responder

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_lat_stage.sv | 47 ++++
 rtl/multicycle_mem_responder.sv | 84 ++++++++
 tb/tb_multicycle_mem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the multicycle memory responder.
// Holds the 16-bit word type, the default latency / address width,
// and the pipeline-entry struct carried through each latency stage.
package mem_pkg;

    typedef logic [15:0] word_t;

    localparam int MEM_LATENCY = 4;
    localparam int MEM_ADDR_W  = 10;

    typedef struct packed {
        logic  valid;
        word_t data;
    } pipe_entry_t;

    // Data is only meaningful alongside its valid bit; otherwise present zero.
    function automatic word_t gate_word(input pipe_entry_t e);
        return e.valid ? e.data : '0;
    endfunction

endpackage

// File: rtl/mem_lat_stage.sv
// One register slot of the read-return pipeline (valid + data).
// The valid bit resets asynchronously so in-flight reads are dropped;
// the payload carries no reset because it is never observed without valid.
// When stall is high the slot holds its contents.
module mem_lat_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  pipe_entry_t entry_i,
    output pipe_entry_t entry_o
);

    logic  valid_d;
    logic  valid_q;
    word_t data_d;
    word_t data_q;

    // Next state: take the upstream entry unless the pipeline is frozen
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (!stall) begin
            valid_d = entry_i.valid;
            data_d  = entry_i.data;
        end
    end

    // Valid bit register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload register, qualified downstream by the valid bit
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign entry_o.valid = valid_q;
    assign entry_o.data  = data_q;

endmodule

// File: rtl/multicycle_mem_responder.sv
// Fixed-latency 16-bit word memory responder.
// Reads sample the array when accepted and return exactly LATENCY cycles
// later through a chain of mem_lat_stage slots; writes update the array
// on the accepting edge and occupy no pipeline slot.
// Optional feature: define MEM_STALL_EN to add a 'stall' input that freezes
// the return pipeline, blanks data_valid and ignores requests while high.
module multicycle_mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY = MEM_LATENCY,
    parameter int ADDR_W  = MEM_ADDR_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
`ifdef MEM_STALL_EN
    input  logic        stall,
`endif
    output logic [15:0] data_out,
    output logic        data_valid
);

    localparam int DEPTH = 1 << ADDR_W;

    logic              stall_w;
    logic [ADDR_W-1:0] word_idx;
    logic              rd_acc;
    logic              wr_acc;
    logic              unused_addr_bits;
    pipe_entry_t       head_entry;
    pipe_entry_t       chain [LATENCY+1];
    word_t             mem_q [DEPTH];

`ifdef MEM_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    // Byte bit 0 and bits above the word index alias onto the same word
    assign unused_addr_bits = ^{addr[15:ADDR_W+1], addr[0]};

    // Request decode: one request per enabled cycle, none while frozen
    always_comb begin
        word_idx = addr[ADDR_W:1];
        rd_acc   = enable & ~wr & ~stall_w;
        wr_acc   = enable &  wr & ~stall_w;
    end

    // Storage array: written on the accepting edge, never reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[word_idx] <= data_in;
        end
    end

    // Read data is captured at acceptance, so later writes cannot disturb it
    always_comb begin
        head_entry.valid = rd_acc;
        head_entry.data  = mem_q[word_idx];
    end

    assign chain[0] = head_entry;

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        mem_lat_stage u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .stall   (stall_w),
            .entry_i (chain[g]),
            .entry_o (chain[g+1])
        );
    end

    // Output: pulse for the entry leaving the last slot, zero data otherwise
    always_comb begin
        data_valid = chain[LATENCY].valid & ~stall_w;
        data_out   = data_valid ? gate_word(chain[LATENCY]) : 16'h0000;
    end

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Bench for multicycle_mem_responder: directed vector table, hand-written
// reset/stall sequences and a randomized run against a queue-based model.
module tb_multicycle_mem_responder;

    localparam int LAT = 4;
    localparam int AW  = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        wr = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        data_valid;

    multicycle_mem_responder #(.LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
`ifdef MEM_STALL_EN
        .stall      (stall),
`endif
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_vcyc = -1;

    // Model: pending returns with their due cycle, plus a word array
    typedef struct {
        int          due;
        logic [15:0] d;
    } pend_t;
    pend_t       pq[$];
    logic [15:0] mem_m [1<<AW];

    typedef struct {
        logic        en;
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        logic        ev;
        logic [15:0] ed;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic add(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic ev, input logic [15:0] ed);
        vec_t v;
        v.en = en; v.wr = w; v.a = a; v.d = d; v.ev = ev; v.ed = ed;
        tbl.push_back(v);
    endtask

    function automatic int widx(input logic [15:0] a);
        return int'((a >> 1) & 16'((1 << AW) - 1));
    endfunction

    task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic st);
        enable = en; wr = w; addr = a; data_in = d; stall = st;
        #1;
    endtask

    task automatic model_check(input logic st);
        logic        ev;
        logic [15:0] ed;
        ev = 1'b0;
        ed = 16'h0000;
        if (!st && pq.size() > 0 && pq[0].due == cyc) begin
            ev = 1'b1;
            ed = pq[0].d;
            void'(pq.pop_front());
        end
        chk("valid", {15'b0, data_valid}, {15'b0, ev});
        chk("data", data_out, ed);
        if (data_valid) last_vcyc = cyc;
    endtask

    task automatic model_step(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d,
                              input logic st);
        pend_t p;
        if (st) begin
            foreach (pq[i]) pq[i].due++;
        end else if (en && w) begin
            mem_m[widx(a)] = d;
        end else if (en) begin
            p.due = cyc + LAT;
            p.d   = mem_m[widx(a)];
            pq.push_back(p);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic cycle(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic st);
        drive(en, w, a, d, st);
        model_check(st);
        model_step(en, w, a, d, st);
        advance();
    endtask

    initial begin
        int c0;
        logic        r_en, r_wr, r_st;
        logic [15:0] r_a, r_d;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", {15'b0, data_valid}, 16'h0000);
        chk("rst_data", data_out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;

        // Directed table: preload, write-then-read, burst, in-flight write, bubbles, aliasing
        for (int k = 0; k < 8; k++) add(1, 1, 16'(16'h0020 + 2*k), 16'(k + 1), 0, 16'h0000);
        add(1, 1, 16'h0040, 16'h1111, 0, 16'h0000);
        add(1, 1, 16'h0010, 16'hBEEF, 0, 16'h0000);
        add(1, 0, 16'h0010, 16'h0000, 0, 16'h0000);
        repeat (3) add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF);
        for (int k = 0; k < 8; k++) begin
            if (k < 4) add(1, 0, 16'(16'h0020 + 2*k), 16'h0000, 0, 16'h0000);
            else       add(1, 0, 16'(16'h0020 + 2*k), 16'h0000, 1, 16'(k - 3));
        end
        for (int k = 5; k <= 8; k++) add(0, 0, 16'h0000, 16'h0000, 1, 16'(k));
        add(1, 0, 16'h0040, 16'h0000, 0, 16'h0000);
        add(1, 1, 16'h0040, 16'h2222, 0, 16'h0000);
        repeat (2) add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 1, 16'h1111);
        add(1, 0, 16'h0040, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0020, 16'hDEAD, 0, 16'h0000);
        add(1, 0, 16'h0020, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(1, 0, 16'h0022, 16'h0000, 1, 16'h2222);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(1, 0, 16'h0810, 16'h0000, 1, 16'h0001);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(1, 0, 16'h0011, 16'h0000, 1, 16'h0002);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF);
        add(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].wr, tbl[i].a, tbl[i].d, 1'b0);
            chk($sformatf("tbl%0d_valid", i), {15'b0, data_valid}, {15'b0, tbl[i].ev});
            chk($sformatf("tbl%0d_data", i), data_out, tbl[i].ed);
            model_check(1'b0);
            model_step(tbl[i].en, tbl[i].wr, tbl[i].a, tbl[i].d, 1'b0);
            advance();
        end

        // Reset with reads in flight: drop them, keep array contents
        cycle(1, 0, 16'h0020, 16'h0000, 0);
        cycle(1, 0, 16'h0022, 16'h0000, 0);
        cycle(1, 0, 16'h0024, 16'h0000, 0);
        cycle(0, 0, 16'h0000, 16'h0000, 0);
        drive(0, 0, 16'h0000, 16'h0000, 0);
        chk("pre_rst_valid", {15'b0, data_valid}, 16'h0001);
        model_check(1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {15'b0, data_valid}, 16'h0000);
        chk("rst_async_data", data_out, 16'h0000);
        pq.delete();
        @(negedge clk);
        cyc++;
        repeat (2) cycle(0, 0, 16'h0000, 16'h0000, 0);
        rst_n = 1'b1;
        c0 = cyc;
        cycle(1, 0, 16'h0020, 16'h0000, 0);
        cycle(1, 0, 16'h0022, 16'h0000, 0);
        cycle(1, 0, 16'h0024, 16'h0000, 0);
        repeat (LAT + 3) cycle(0, 0, 16'h0000, 16'h0000, 0);
        chk("post_rst_last_return", 16'(last_vcyc - c0), 16'(2 + LAT));

`ifdef MEM_STALL_EN
        // Stall mid-flight: return slips by the stall length
        c0 = cyc;
        cycle(1, 0, 16'h0010, 16'h0000, 0);
        cycle(0, 0, 16'h0000, 16'h0000, 0);
        repeat (3) cycle(1, 0, 16'h0020, 16'h0000, 1);
        repeat (LAT + 2) cycle(0, 0, 16'h0000, 16'h0000, 0);
        chk("stall_return_cycle", 16'(last_vcyc - c0), 16'(LAT + 3));
`endif

        // Randomized run over a small aliased address window
        for (int k = 0; k < 16; k++) cycle(1, 1, 16'(2*k), 16'($urandom), 0);
        for (int n = 0; n < 400; n++) begin
            r_en = ($urandom_range(0, 3) != 0);
            r_wr = ($urandom_range(0, 2) == 0);
            r_a  = 16'($urandom_range(0, 15) * 2 + $urandom_range(0, 1) + ($urandom_range(0, 3) << 11));
            r_d  = 16'($urandom);
`ifdef MEM_STALL_EN
            r_st = ($urandom_range(0, 5) == 0);
`else
            r_st = 1'b0;
`endif
            cycle(r_en, r_wr, r_a, r_d, r_st);
        end
        repeat (LAT + 4) cycle(0, 0, 16'h0000, 16'h0000, 0);
        chk("drained_queue", 16'(pq.size()), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
